// File: rtl/fp32_to_fp8_e4m3_quantizer_if.sv
// ----------------------------------------------------------------------------
// fp32_to_fp8_e4m3_quantizer_if
// Handshake bundle for the FP32 -> FP8 E4M3 quantizer.
//   in_valid  / in_ready / in_data[31:0]  : binary32 input stream
//   out_valid / out_ready / out_data[7:0] : E4M3 result stream
//   out_sat, out_uflow                    : per-result status, aligned to out_data
//   sat_count[15:0]                       : saturating results delivered (sticky at max)
// master = producer/consumer side, slave = quantizer side.
// ----------------------------------------------------------------------------
interface fp32_to_fp8_e4m3_quantizer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_sat;
   logic        out_uflow;
   logic [15:0] sat_count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat, out_uflow, sat_count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat, out_uflow, sat_count
   );
endinterface

// File: rtl/fp32_to_fp8_e4m3_quantizer.sv
// ----------------------------------------------------------------------------
// fp32_to_fp8_e4m3_quantizer
// 3-stage pipelined binary32 -> E4M3 (bias 7, no Inf/NaN codes, max 480 = 0x7F)
// converter with round-to-nearest-even, saturation and a saturation counter.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave modport of fp32_to_fp8_e4m3_quantizer_if (valid/ready both
//            sides, result status flags, sat_count)
// Stages: S1 unpack/classify, S2 align/round, S3 pack/saturate. All stages
// advance together whenever S3 is empty or being drained.
// ----------------------------------------------------------------------------
module fp32_to_fp8_e4m3_quantizer (
   input  logic clk,
   input  logic rst_n,
   fp32_to_fp8_e4m3_quantizer_if.slave bus
);

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_INF,
      CLS_NAN,
      CLS_NORM,
      CLS_SUB
   } cls_t;

   // ---------------- pipeline state ----------------
   logic        r_s1_valid, r_s2_valid, r_s3_valid;
   logic        r_s1_sign,  r_s2_sign;
   cls_t        r_s1_cls,   r_s2_cls;
   logic [7:0]  r_s1_exp;      // E+7 for the normal path
   logic [4:0]  r_s1_sh;       // subnormal right shift minus one, clamped
   logic [22:0] r_s1_m;
   logic        r_s2_mnz;      // fp32 mantissa nonzero (zero-class underflow)
   logic [7:0]  r_s2_exp;
   logic [2:0]  r_s2_frac;
   logic [7:0]  r_out_data;
   logic        r_out_sat;
   logic        r_out_uflow;
   logic [15:0] r_sat_count;

   logic        w_adv;
   logic        w_out_hs;

   assign w_adv    = !r_s3_valid || bus.out_ready;
   assign w_out_hs = r_s3_valid && bus.out_ready;

   // ---------------- S1: unpack / classify ----------------
   logic [7:0]  w_e;
   logic [22:0] w_m;
   logic [7:0]  w_sh8;
   cls_t        w_cls;

   assign w_e   = bus.in_data[30:23];
   assign w_m   = bus.in_data[22:0];
   // 120-e equals (-6-E)-1; the -1 lets S2 use a 47-bit window with no unused bits
   assign w_sh8 = 8'd120 - w_e;

   always_comb begin
      w_cls = CLS_SUB;
      if (w_e == 8'hFF)        w_cls = (w_m == '0) ? CLS_INF : CLS_NAN;
      else if (w_e == '0)      w_cls = CLS_ZERO;
      else if (w_e >= 8'd121)  w_cls = CLS_NORM;
   end

   // ---------------- S2: align / round ----------------
   logic [46:0] w_t;
   logic [2:0]  w_f3;
   logic        w_g, w_st, w_up;
   logic [3:0]  w_sum;
   logic [7:0]  w_exp2;

   always_comb begin
      // A clamped shift of 24 (true shift 25) already pushes the guard bit out
      // and leaves the hidden one in sticky, which covers every larger shift too.
      w_t = {1'b1, r_s1_m, 23'b0} >> r_s1_sh;
      if (r_s1_cls == CLS_SUB) begin
         w_f3 = w_t[46:44];
         w_g  = w_t[43];
         w_st = |w_t[42:0];
      end else begin
         w_f3 = r_s1_m[22:20];
         w_g  = r_s1_m[19];
         w_st = |r_s1_m[18:0];
      end
      w_up   = w_g && (w_st || w_f3[0]);
      w_sum  = {1'b0, w_f3} + {3'b0, w_up};
      // carry-out moves into the exponent; on the subnormal path 7+1 gives 0x08
      w_exp2 = ((r_s1_cls == CLS_SUB) ? 8'd0 : r_s1_exp) + {7'b0, w_sum[3]};
   end

   // ---------------- S3: pack / saturate ----------------
   logic [7:0] w_data;
   logic       w_sat, w_uf;

   always_comb begin
      w_data = '0;
      w_sat  = 1'b0;
      w_uf   = 1'b0;
      case (r_s2_cls)
         CLS_ZERO: w_uf = r_s2_mnz;
         CLS_INF: begin
            w_data = {r_s2_sign, 7'h7F};
            w_sat  = 1'b1;
         end
         CLS_NAN: begin
            w_data = 8'h7F;
            w_sat  = 1'b1;
         end
         default: begin
            if (r_s2_exp > 8'd15) begin
               w_data = {r_s2_sign, 7'h7F};
               w_sat  = 1'b1;
            end else if ((r_s2_exp == '0) && (r_s2_frac == '0)) begin
               w_uf = 1'b1;
            end else begin
               w_data = {r_s2_sign, r_s2_exp[3:0], r_s2_frac};
            end
         end
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s3_valid  <= 1'b0;
         r_s1_sign   <= 1'b0;
         r_s2_sign   <= 1'b0;
         r_s1_cls    <= CLS_ZERO;
         r_s2_cls    <= CLS_ZERO;
         r_s1_exp    <= '0;
         r_s1_sh     <= '0;
         r_s1_m      <= '0;
         r_s2_mnz    <= 1'b0;
         r_s2_exp    <= '0;
         r_s2_frac   <= '0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_out_uflow <= 1'b0;
         r_sat_count <= '0;
      end else begin
         if (w_adv) begin
            r_s1_valid  <= bus.in_valid;
            r_s1_sign   <= bus.in_data[31];
            r_s1_cls    <= w_cls;
            r_s1_exp    <= w_e - 8'd120;
            r_s1_sh     <= (w_sh8 > 8'd24) ? 5'd24 : w_sh8[4:0];
            r_s1_m      <= w_m;

            r_s2_valid  <= r_s1_valid;
            r_s2_sign   <= r_s1_sign;
            r_s2_cls    <= r_s1_cls;
            r_s2_mnz    <= (r_s1_m != '0);
            r_s2_exp    <= w_exp2;
            r_s2_frac   <= w_sum[2:0];

            r_s3_valid  <= r_s2_valid;
            r_out_data  <= w_data;
            r_out_sat   <= w_sat;
            r_out_uflow <= w_uf;
         end
         if (w_out_hs && r_out_sat && (r_sat_count != '1))
            r_sat_count <= r_sat_count + 16'd1;
      end
   end

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_s3_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sat   = r_out_sat;
   assign bus.out_uflow = r_out_uflow;
   assign bus.sat_count = r_sat_count;

endmodule
